mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner and the latched
// memory-side request fields, plus the conflict-resolution helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  localparam logic [3:0] IfBe = 4'hF;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_fields_t;

  localparam mem_fields_t MemFieldsReset = '{we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};

  // On a conflict, fixed priority picks the LSU; round-robin picks whoever was not
  // granted last.
  function automatic owner_e arb_pick(input logic   if_req,
                                      input logic   lsu_req,
                                      input logic   lsu_prio,
                                      input owner_e last_grant);
    owner_e win;
    if (if_req && lsu_req) begin
      if (lsu_prio) begin
        win = OwnLsu;
      end else begin
        win = (last_grant == OwnIf) ? OwnLsu : OwnIf;
      end
    end else if (lsu_req) begin
      win = OwnLsu;
    end else begin
      win = OwnIf;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and LSU request ports onto one memory port with at most one
// transaction outstanding; fetch responses can be discarded by a pipeline flush.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LSU_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst_i,

  input  logic        if_en_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_valid_o,

  input  logic        lsu_en_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_valid_o,

  input  logic        flush_i,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic LsuPrio = (LSU_PRIO != 0);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q, last_d;
  logic        drop_q, drop_d;
  mem_fields_t fields_q, fields_d;

  logic        grant;
  logic        if_cand;
  logic        lsu_cand;
  owner_e      win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    drop_d      = drop_q;
    fields_d    = fields_q;
    if_valid_o  = 1'b0;
    if_data_o   = 32'h0;
    lsu_valid_o = 1'b0;
    lsu_rdata_o = 32'h0;
    grant       = 1'b0;
    if_cand     = if_en_i;
    lsu_cand    = lsu_en_i;
    win         = OwnIf;

    unique case (state_q)
      StIdle: begin
        grant = if_en_i || lsu_en_i;
      end
      StReq: begin
        if (flush_i && (owner_q == OwnIf)) begin
          drop_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          // The requester just served still holds en this cycle; keep it out of the race.
          if (owner_q == OwnIf) begin
            if (!drop_q && !flush_i) begin
              if_valid_o = 1'b1;
              if_data_o  = mem_rdata_i;
            end
            if_cand = 1'b0;
          end else begin
            lsu_valid_o = 1'b1;
            lsu_rdata_o = mem_rdata_i;
            lsu_cand    = 1'b0;
          end
          drop_d  = 1'b0;
          state_d = StIdle;
          grant   = if_cand || lsu_cand;
        end else if (flush_i && (owner_q == OwnIf)) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (grant) begin
      win     = arb_pick(if_cand, lsu_cand, LsuPrio, last_q);
      owner_d = win;
      last_d  = win;
      state_d = StReq;
      drop_d  = 1'b0;
      if (win == OwnLsu) begin
        fields_d = '{we: lsu_we_i, be: lsu_be_i, addr: lsu_addr_i, wdata: lsu_wdata_i};
      end else begin
        fields_d = '{we: 1'b0, be: IfBe, addr: if_addr_i, wdata: 32'h0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= OwnIf;
      last_q   <= OwnIf;
      drop_q   <= 1'b0;
      fields_q <= MemFieldsReset;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      drop_q   <= drop_d;
      fields_q <= fields_d;
    end
  end

  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = fields_q.we;
  assign mem_be_o    = fields_q.be;
  assign mem_addr_o  = fields_q.addr;
  assign mem_wdata_o = fields_q.wdata;

endmodule
